// File: rtl/btb_predictor_if.sv
// Fetch lookup and MEM-stage training signals of the branch target buffer.
// The predictor is the slave; the pipeline side is the master.
interface btb_predictor_if;
    logic [31:0] IF_PC;
    logic        Hit;
    logic        Pred_Taken;
    logic [31:0] Pred_Target;
    logic [31:0] Next_PC;
    logic        EX_MEM_Branch;
    logic [31:0] EX_MEM_PC;
    logic        EX_MEM_Taken;
    logic [31:0] EX_MEM_Update;
    logic        Mispredict;

    modport master (
        output IF_PC, EX_MEM_Branch, EX_MEM_PC,
        output EX_MEM_Taken, EX_MEM_Update,
        input  Hit, Pred_Taken, Pred_Target,
        input  Next_PC, Mispredict
    );

    modport slave (
        input  IF_PC, EX_MEM_Branch, EX_MEM_PC,
        input  EX_MEM_Taken, EX_MEM_Update,
        output Hit, Pred_Taken, Pred_Target,
        output Next_PC, Mispredict
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from MEM.
// Define BTB_BYPASS_EN to forward a same-PC update into the IF lookup.
module btb_predictor #(
    parameter int INDEX_BITS = 4
) (
    input logic           Clk,
    input logic           Rst,
    btb_predictor_if.slave bus
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;

    logic        valid_q  [ENTRIES];
    logic        valid_d  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    tag_t        tag_d    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [31:0] target_d [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
    logic [1:0]  ctr_d    [ENTRIES];
    logic        mis_q;
    logic        mis_d;

    idx_t        upd_idx;
    tag_t        upd_tag;
    logic        upd_hit;
    logic        upd_pt;
    logic [31:0] upd_tgt;

    idx_t        lk_idx;
    tag_t        lk_tag;
    logic        rd_valid;
    tag_t        rd_tag;
    logic [31:0] rd_target;
    logic [1:0]  rd_ctr;
    logic        lk_hit;
    logic        lk_pt;

    logic        unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.IF_PC[1:0], bus.EX_MEM_PC[1:0]};

    assign upd_idx = bus.EX_MEM_PC[INDEX_BITS+1:2];
    assign upd_tag = bus.EX_MEM_PC[31:INDEX_BITS+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_pt  = upd_hit && ctr_q[upd_idx][1];
    assign upd_tgt = target_q[upd_idx];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        mis_d    = 1'b0;
        if (bus.EX_MEM_Branch) begin
            mis_d = (upd_pt != bus.EX_MEM_Taken) ||
                    (bus.EX_MEM_Taken && upd_pt &&
                     (upd_tgt != bus.EX_MEM_Update));
            if (upd_hit) begin
                if (bus.EX_MEM_Taken) begin
                    target_d[upd_idx] = bus.EX_MEM_Update;
                    if (ctr_q[upd_idx] != 2'b11)
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (bus.EX_MEM_Taken) begin
                // Allocation evicts whatever aliased into this slot.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bus.EX_MEM_Update;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    assign lk_idx = bus.IF_PC[INDEX_BITS+1:2];
    assign lk_tag = bus.IF_PC[31:INDEX_BITS+2];

`ifdef BTB_BYPASS_EN
    logic byp;
    assign byp = bus.EX_MEM_Branch &&
                 (bus.IF_PC[31:2] == bus.EX_MEM_PC[31:2]);
    assign rd_valid  = byp ? valid_d[lk_idx]  : valid_q[lk_idx];
    assign rd_tag    = byp ? tag_d[lk_idx]    : tag_q[lk_idx];
    assign rd_target = byp ? target_d[lk_idx] : target_q[lk_idx];
    assign rd_ctr    = byp ? ctr_d[lk_idx]    : ctr_q[lk_idx];
`else
    assign rd_valid  = valid_q[lk_idx];
    assign rd_tag    = tag_q[lk_idx];
    assign rd_target = target_q[lk_idx];
    assign rd_ctr    = ctr_q[lk_idx];
`endif

    assign lk_hit = rd_valid && (rd_tag == lk_tag);
    assign lk_pt  = lk_hit && rd_ctr[1];

    assign bus.Hit         = lk_hit;
    assign bus.Pred_Taken  = lk_pt;
    assign bus.Pred_Target = lk_hit ? rd_target : 32'd0;
    assign bus.Next_PC     = lk_pt ? rd_target : bus.IF_PC + 32'd4;
    assign bus.Mispredict  = mis_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
            mis_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            mis_q    <= mis_d;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed plan plus random traffic
// checked against an entry-level behavioural model of the table.
module tb_btb_predictor;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    btb_predictor_if bus ();
    btb_predictor dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    typedef struct {
        bit              v;
        bit [31:0]       tag;
        bit [31:0]       tgt;
        int              ctr;
    } ent_t;

    typedef struct {
        string     nm;
        bit        hit;
        bit        pt;
        bit [31:0] tgt;
        bit [31:0] npc;
        bit        mis;
    } exp_t;

    ent_t tbl [16];
    exp_t q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit        prev_rst = 1'b1;
    bit        prev_br  = 1'b0;
    bit [31:0] prev_pc  = 0;
    bit        prev_tk  = 1'b0;
    bit [31:0] prev_tgt = 0;

    function automatic int idx_of(bit [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit [31:0] tag_of(bit [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit is_hit(ent_t e, bit [31:0] pc);
        return e.v && (e.tag == tag_of(pc));
    endfunction

    function automatic ent_t trained(ent_t e, bit [31:0] pc,
                                     bit tk, bit [31:0] t);
        ent_t r = e;
        if (is_hit(e, pc)) begin
            if (tk) begin
                r.tgt = t;
                r.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
            end else begin
                r.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
            end
        end else if (tk) begin
            r.v = 1; r.tag = tag_of(pc); r.tgt = t; r.ctr = 2;
        end
        return r;
    endfunction

    task automatic chk(string nm, string f, bit [31:0] act, bit [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, ex);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "Hit", 32'(bus.Hit), 32'(e.hit));
            chk(e.nm, "Pred_Taken", 32'(bus.Pred_Taken), 32'(e.pt));
            chk(e.nm, "Pred_Target", bus.Pred_Target, e.tgt);
            chk(e.nm, "Next_PC", bus.Next_PC, e.npc);
            chk(e.nm, "Mispredict", 32'(bus.Mispredict), 32'(e.mis));
        end
    end

    task automatic cycle(string nm, bit rst, bit [31:0] ifpc, bit br,
                         bit [31:0] pc, bit tk, bit [31:0] t);
        exp_t e;
        ent_t le;
        bit   mis;
        int   ui;
        @(posedge Clk);
        #1;
        mis = 0;
        if (prev_rst) begin
            foreach (tbl[i]) tbl[i] = '{v: 0, tag: 0, tgt: 0, ctr: 1};
        end else if (prev_br) begin
            bit        ppt;
            bit [31:0] ptg;
            ui  = idx_of(prev_pc);
            ppt = is_hit(tbl[ui], prev_pc) && tbl[ui].ctr >= 2;
            ptg = tbl[ui].tgt;
            mis = (ppt != prev_tk) || (prev_tk && ppt && ptg != prev_tgt);
            tbl[ui] = trained(tbl[ui], prev_pc, prev_tk, prev_tgt);
        end
        Rst = rst;
        bus.IF_PC = ifpc;
        bus.EX_MEM_Branch = br;
        bus.EX_MEM_PC = pc;
        bus.EX_MEM_Taken = tk;
        bus.EX_MEM_Update = t;
        le = tbl[idx_of(ifpc)];
`ifdef BTB_BYPASS_EN
        if (br && (ifpc / 4) == (pc / 4)) le = trained(le, pc, tk, t);
`endif
        e.nm  = nm;
        e.hit = is_hit(le, ifpc);
        e.pt  = e.hit && le.ctr >= 2;
        e.tgt = e.hit ? le.tgt : 0;
        e.npc = e.pt ? e.tgt : ifpc + 4;
        e.mis = mis;
        q.push_back(e);
        prev_rst = rst; prev_br = br; prev_pc = pc;
        prev_tk = tk; prev_tgt = t;
    endtask

    task automatic look(string nm, bit [31:0] a);
        cycle(nm, 0, a, 0, 0, 0, 0);
    endtask

    task automatic upd(string nm, bit [31:0] pc, bit tk, bit [31:0] t);
        cycle(nm, 0, 32'h0040_0010, 1, pc, tk, t);
    endtask

    initial begin
        bus.IF_PC = 0; bus.EX_MEM_Branch = 0; bus.EX_MEM_PC = 0;
        bus.EX_MEM_Taken = 0; bus.EX_MEM_Update = 0;
        cycle("rst", 1, 32'h0040_0010, 0, 0, 0, 0);
        cycle("rst2", 1, 32'h0040_0010, 0, 0, 0, 0);
        look("reset_lookup", 32'h0040_0010);
        upd("cold_alloc", 32'h0040_0020, 1, 32'h0040_0100);
        look("after_alloc", 32'h0040_0020);
        upd("nt1", 32'h0040_0020, 0, 0);
        look("after_nt1", 32'h0040_0020);
        upd("nt2", 32'h0040_0020, 0, 0);
        look("after_nt2", 32'h0040_0020);
        upd("nt3", 32'h0040_0020, 0, 0);
        look("after_nt3", 32'h0040_0020);
        upd("b2b_a", 32'h0040_0020, 1, 32'h0040_0100);
        upd("b2b_b", 32'h0040_0020, 1, 32'h0040_0100);
        upd("b2b_c", 32'h0040_0020, 1, 32'h0040_0100);
        look("trained_st", 32'h0040_0022);
        upd("retarget", 32'h0040_0020, 1, 32'h0040_0180);
        look("after_retarget", 32'h0040_0020);
        upd("alias", 32'h0040_0060, 1, 32'h0040_0200);
        look("alias_old", 32'h0040_0020);
        look("alias_new", 32'h0040_0060);
        cycle("rst_upd", 1, 32'h0040_0060, 1,
              32'h0040_0060, 1, 32'h0040_0300);
        look("post_rst_a", 32'h0040_0060);
        look("post_rst_b", 32'h0040_0020);
        cycle("same_cycle", 0, 32'h0040_0040, 1,
              32'h0040_0040, 1, 32'h0040_0400);
        look("same_cycle_next", 32'h0040_0040);
        for (int n = 0; n < 600; n++) begin
            bit [31:0] a, b;
            a = 32'h0040_0000 + 4 * $urandom_range(0, 47) + $urandom_range(0, 3);
            b = ($urandom_range(0, 3) == 0) ? a :
                32'h0040_0000 + 4 * $urandom_range(0, 47);
            if ($urandom_range(0, 15) == 0) b = b ^ 32'h1000_0000;
            cycle("rand", $urandom_range(0, 99) == 0, a,
                  $urandom_range(0, 2) != 0, b, $urandom_range(0, 1) == 1,
                  32'h0040_0000 + 4 * $urandom_range(0, 255));
        end
        look("drain", 32'h0040_0010);
        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer with per-entry 2-bit saturating direction counters for the 5-stage MIPS pipeline. Looked up combinationally by IF with the current PC to produce the predicted next PC. Trained by the MEM stage from the EX/MEM branch-resolution fields: branch flag, branch PC, resolved direction and resolved target. Direct-mapped, with valid and tag per entry.

## Interface
- INDEX_BITS, 4: log2 of entry count (16 entries); index = PC[INDEX_BITS+1:2].
- TAG_BITS, derived 30-INDEX_BITS: tag = PC[31:INDEX_BITS+2]; not overridable.

- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  reset, synchronous, active-high.
- IF_PC  in  32  fetch PC for lookup.
- Hit  out  1  IF_PC index entry valid and tag matches.
- Pred_Taken  out  1  Hit and counter[1]==1.
- Pred_Target  out  32  stored target of indexed entry, 0 when not Hit.
- Next_PC  out  32  Pred_Taken ? Pred_Target : IF_PC+4 (mod 2^32).
- EX_MEM_Branch  in  1  update strobe; resolved branch in MEM this cycle.
- EX_MEM_PC  in  32  PC of the resolved branch.
- EX_MEM_Taken  in  1  resolved direction.
- EX_MEM_Update  in  32  resolved taken target.
- Mispredict  out  1  registered; set the cycle after an update whose stored prediction differed from resolution.

## Operation
- Per entry: valid (1b), tag (TAG_BITS), target (32b), ctr (2b: 00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup is purely combinational from registered state. Hit, Pred_Taken, Pred_Target and Next_PC depend only on IF_PC and the table.
- Update (EX_MEM_Branch=1), using the entry indexed by EX_MEM_PC:
  - Tag hit, taken: ctr saturating +1 (11 stays 11); target <= EX_MEM_Update.
  - Tag hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate. valid<=1, tag<=EX_MEM_PC tag, target<=EX_MEM_Update, ctr<=10. Any old entry is overwritten.
  - Miss, not taken: no table change.
- Mispredict: the prediction is recomputed for EX_MEM_PC from pre-update state. predicted_taken = hit & ctr[1]; predicted_target = stored target.
  - Mispredict <= EX_MEM_Branch & ((predicted_taken != EX_MEM_Taken) | (EX_MEM_Taken & predicted_taken & predicted_target != EX_MEM_Update)).
  - Mispredict is 0 in any cycle following EX_MEM_Branch=0.
- PC[1:0] are ignored for index and tag.

## Timing
- Lookup latency 0 cycles. Update is visible to lookup on the cycle after the posedge that samples it.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents, unless BTB_BYPASS_EN is defined.
- Reset values:
  - All valid=0, ctr=01, target=0, tag=0, Mispredict=0.
  - With Rst=0 and the table in reset state: Hit=0, Pred_Taken=0, Pred_Target=0, Next_PC=IF_PC+4.
- Rst has priority over an update in the same cycle; the update is dropped.
- Rst asserted mid-operation clears the whole table in one cycle; no multi-cycle flush.
- Back-to-back updates to the same entry on consecutive cycles each see the prior cycle's result; counters step once per cycle.

## Configuration
- BTB_BYPASS_EN defined: when EX_MEM_Branch=1 and IF_PC[31:2]==EX_MEM_PC[31:2] in the same cycle, lookup outputs reflect the post-update entry. This covers hit, counter and target, including a fresh allocation. Mispredict is unaffected.
- Not defined: lookup always reads registered state; no bypass path exists.

## Test plan
- Reset then IF_PC=0x00400010 -> Hit=0, Pred_Taken=0, Next_PC=0x00400014.
- Update PC=0x00400020, taken, target 0x00400100; next cycle IF_PC=0x00400020 -> Hit=1, Pred_Taken=1, Next_PC=0x00400100, Mispredict=1 (cold miss).
- Same branch not-taken twice -> ctr 10->01->00; lookup Hit=1, Pred_Taken=0, Next_PC=0x00400024. Mispredict=1 after the first, 0 after the second. A third not-taken keeps ctr=00.
- Aliasing: train 0x00400020 taken, then update 0x00400060 taken to 0x00400200 (same index 8) -> lookup 0x00400020 Hit=0, lookup 0x00400060 Hit=1 with target 0x00400200.
- Taken with changed target (entry ctr=11, target 0x00400100; resolves to 0x00400180) -> Mispredict=1, stored target 0x00400180, ctr stays 11.
- Rst and update in the same cycle -> all lookups Hit=0. With BTB_BYPASS_EN, a same-cycle lookup/update of 0x00400040 taken gives Hit=1 in that cycle; without it, Hit=0.
